// File: rtl/gpu_bus_pkg.sv
// gpu_bus_pkg: shared widths and FSM encoding for the GPU 8-bit command bus
package gpu_bus_pkg;
  localparam int BYTES_PER_INSTR = 4;
  localparam int BUS_W = 8;
  localparam int INSTR_W = 32;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;
endpackage

// File: rtl/gpu_instr_fifo.sv
// gpu_instr_fifo: synchronous first-word-fall-through FIFO with active-low flush
module gpu_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign o_full = o_count == (AW+1)'(DEPTH);
  assign o_empty = o_count == '0;
  assign do_push = i_push && !o_full;
  assign do_pop = i_pop && !o_empty;
  assign o_head = mem[rd_q];
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      o_count <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      o_count <= o_count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_q] <= i_data;
  end
endmodule

// File: rtl/gpu_bus_master.sv
// gpu_bus_master: queues 32-bit GPU instructions and writes each as 4 acked bytes, MSB first
module gpu_bus_master
  import gpu_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_instr_valid,
  output logic               o_instr_ready,
  output logic               o_en,
  output logic               o_we,
  output logic [BUS_W-1:0]   o_data,
  input  logic               i_ack,
  input  logic               i_busy,
  output logic               o_idle,
  output logic               o_timeout
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  state_t state_q, state_d;
  logic [INSTR_W-1:0] head, shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BUS_W-1:0] data_d;
  logic en_d, timeout_d, full, empty, pop, hit, last;
  logic [$clog2(FIFO_DEPTH):0] count;
  gpu_instr_fifo #(.DEPTH(FIFO_DEPTH), .W(INSTR_W)) u_fifo (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_push(i_instr_valid),
    .i_data(i_instr),
    .i_pop(pop),
    .o_head(head),
    .o_full(full),
    .o_empty(empty),
    .o_count(count)
  );
  assign o_instr_ready = !full;
  assign o_idle = empty && state_q == ST_IDLE;
  assign pop = state_q == ST_IDLE && !empty && !i_busy;
  assign hit = timer_q == TW'(ACK_TIMEOUT - 1);
  assign last = idx_q == 3'(BYTES_PER_INSTR);
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = pop ? ST_SEND : ST_IDLE;
      ST_SEND: state_d = (i_ack || hit) ? ST_GAP : ST_SEND;
      ST_GAP:  state_d = i_ack ? ST_GAP : (last ? ST_IDLE : ST_SEND);
      default: state_d = ST_IDLE;
    endcase
  end
  // Next values of the registered bus outputs and datapath
  always_comb begin
    en_d = o_en;
    data_d = o_data;
    timeout_d = 1'b0;
    shift_d = shift_q;
    idx_d = idx_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: if (pop) begin
        en_d = 1'b1;
        data_d = head[INSTR_W-1 -: BUS_W];
        shift_d = head;
        idx_d = '0;
        timer_d = '0;
      end
      ST_SEND: if (i_ack) begin
        en_d = 1'b0;
        shift_d = shift_q << BUS_W;
        idx_d = idx_q + 3'd1;
      end else begin
        timer_d = timer_q + TW'(1);
        if (hit) begin
          en_d = 1'b0;
          timeout_d = 1'b1;
          idx_d = 3'(BYTES_PER_INSTR);
        end
      end
      ST_GAP: if (!i_ack && !last) begin
        en_d = 1'b1;
        data_d = shift_q[INSTR_W-1 -: BUS_W];
        timer_d = '0;
      end
      default: en_d = 1'b0;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_en <= 1'b0;
      o_we <= 1'b0;
      o_data <= '0;
      o_timeout <= 1'b0;
      shift_q <= '0;
      idx_q <= '0;
      timer_q <= '0;
    end else begin
      o_en <= en_d;
      o_we <= en_d;
      o_data <= data_d;
      o_timeout <= timeout_d;
      shift_q <= shift_d;
      idx_q <= idx_d;
      timer_q <= timer_d;
    end
  end
endmodule
